// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary ROWS x COLS systolic matrix multiplier.
// Computes C = A(ROWS x K) * B(K x COLS) with a run-time K. Operands enter one beat
// at a time (an A column and a B row). They are skewed internally, reduced in place
// in each PE, and the results are drained one row per handshake.
module systolic_mm_engine #(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 32,
  parameter  int K_MAX  = 256,
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int RW     = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   signed_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_in,
  input  logic [COLS*DATA_W-1:0] b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // The flush counter counts 0..ROWS+COLS-2. The product is a signed
  // (DATA_W+1)x(DATA_W+1) multiply, so one shared datapath covers both modes.
  localparam int FW = $clog2(ROWS + COLS);
  localparam int PW = 2 * DATA_W + 2;

  localparam logic [KW-1:0] K_CAP      = KW'(K_MAX);
  localparam logic [KW-1:0] K_ONE      = KW'(1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [FW-1:0] F_ONE      = FW'(1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [RW-1:0] R_ONE      = RW'(1);

  logic [1:0]    state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_cnt;
  logic [KW-1:0] k_eff;
  logic [FW-1:0] flush_cnt;
  logic          sgn_q;

  logic accept;
  logic clear;
  logic advance;
  logic last_beat;
  logic row_hs;

  logic [ROWS*DATA_W-1:0] a_beat;
  logic [COLS*DATA_W-1:0] b_beat;

  logic [ROWS-1:0][DATA_W-1:0] a_skew;
  logic [COLS-1:0][DATA_W-1:0] b_skew;

  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] a_pe;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] b_pe;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  acc;

  assign k_eff     = (k_len > K_CAP) ? K_CAP : k_len;
  assign in_ready  = (state == S_LOAD);
  assign accept    = in_valid & in_ready;
  assign clear     = (state == S_IDLE) & start;
  assign advance   = (state == S_LOAD) | (state == S_FLUSH);
  assign last_beat = accept & (beat_cnt == (k_q - K_ONE));
  assign out_valid = (state == S_DRAIN);
  assign row_hs    = out_valid & out_ready;
  assign busy      = (state != S_IDLE);

  // A cycle without an accepted beat feeds zeros, so a bubble adds nothing to any sum.
  assign a_beat = accept ? a_in : '0;
  assign b_beat = accept ? b_in : '0;

  // Skew A: lane i passes through a delay line of i registers.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    if (gi == 0) begin : g_direct
      assign a_skew[gi] = a_beat[gi*DATA_W +: DATA_W];
    end else begin : g_delay
      logic [DATA_W-1:0] dly [gi];
      // Shift the A lane down its delay line. Start or reset empties the line.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int d = 0; d < gi; d++) dly[d] <= '0;
        end else begin
          dly[0] <= a_beat[gi*DATA_W +: DATA_W];
          for (int d = 1; d < gi; d++) dly[d] <= dly[d-1];
        end
      end
      assign a_skew[gi] = dly[gi-1];
    end
  end

  // Skew B: lane j passes through a delay line of j registers.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
    if (gj == 0) begin : g_direct
      assign b_skew[gj] = b_beat[gj*DATA_W +: DATA_W];
    end else begin : g_delay
      logic [DATA_W-1:0] dly [gj];
      // Shift the B lane down its delay line. Start or reset empties the line.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int d = 0; d < gj; d++) dly[d] <= '0;
        end else begin
          dly[0] <= b_beat[gj*DATA_W +: DATA_W];
          for (int d = 1; d < gj; d++) dly[d] <= dly[d-1];
        end
      end
      assign b_skew[gj] = dly[gj-1];
    end
  end

  // PE grid. Beat k reaches PE(i,j) exactly i+j cycles after it is accepted, on both
  // the A path and the B path, so the operand pairs stay aligned even with bubbles.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign a_pe[gi][0] = a_skew[gi];
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
      logic [ACC_W-1:0]       acc_q;
      logic signed [DATA_W:0] a_ext;
      logic signed [DATA_W:0] b_ext;
      logic signed [PW-1:0]   prod;

      if (gi == 0) begin : g_b_top
        assign b_pe[0][gj] = b_skew[gj];
      end

      assign a_ext = {sgn_q & a_pe[gi][gj][DATA_W-1], a_pe[gi][gj]};
      assign b_ext = {sgn_q & b_pe[gi][gj][DATA_W-1], b_pe[gi][gj]};
      assign prod  = PW'(a_ext) * PW'(b_ext);

      // Accumulate the extended product while the array is advancing. Sums wrap at ACC_W.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          acc_q <= '0;
        end else if (advance) begin
          acc_q <= acc_q + ACC_W'(prod);
        end
      end
      assign acc[gi][gj] = acc_q;

      if (gj < COLS - 1) begin : g_a_fwd
        logic [DATA_W-1:0] a_q;
        // Pass the A operand one PE to the right.
        always_ff @(posedge clk) begin
          if (rst || clear) a_q <= '0;
          else              a_q <= a_pe[gi][gj];
        end
        assign a_pe[gi][gj+1] = a_q;
      end

      if (gi < ROWS - 1) begin : g_b_fwd
        logic [DATA_W-1:0] b_q;
        // Pass the B operand one PE down.
        always_ff @(posedge clk) begin
          if (rst || clear) b_q <= '0;
          else              b_q <= b_pe[gi][gj];
        end
        assign b_pe[gi+1][gj] = b_q;
      end
    end
  end

  // Job control: beat counting, the fixed-length flush, row-serial drain and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_q       <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      sgn_q     <= 1'b0;
      out_row   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_q      <= k_eff;
            sgn_q    <= signed_mode;
            beat_cnt <= '0;
            out_row  <= '0;
            state    <= (k_eff == '0) ? S_DRAIN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (last_beat) begin
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else if (accept) begin
            beat_cnt <= beat_cnt + K_ONE;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= S_DRAIN;
          else                         flush_cnt <= flush_cnt + F_ONE;
        end
        S_DRAIN: begin
          if (row_hs) begin
            if (out_row == ROW_LAST) begin
              out_row <= '0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              out_row <= out_row + R_ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Present the accumulators of the selected row. The output is zero when no row is offered.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int j = 0; j < COLS; j++) out_data[j*ACC_W +: ACC_W] = acc[out_row][j];
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: randomized and directed jobs on a 3x4 engine.
// Results are compared against a plain matrix-product reference model.
module tb_systolic_mm_engine;

  localparam int ROWS   = 3;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int K_MAX  = 8;
  localparam int KW     = $clog2(K_MAX + 1);
  localparam int RW     = $clog2(ROWS);
  localparam int AW     = ROWS * DATA_W;
  localparam int BW     = COLS * DATA_W;
  localparam int OW     = COLS * ACC_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          signed_mode;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a_in;
  logic [BW-1:0] b_in;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          done;

  int check_count = 0;
  int pass_count  = 0;

  // Operand matrices for the current job, raw DATA_W-bit values.
  int op_a [ROWS][K_MAX];
  int op_b [K_MAX][COLS];

  always #5 clk = ~clk;

  systolic_mm_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_MAX(K_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  function automatic longint ext_val(input int raw, input bit sgn);
    if (sgn && raw >= (1 << (DATA_W - 1))) return longint'(raw) - (longint'(1) << DATA_W);
    return longint'(raw);
  endfunction

  // Reference: plain dot products over k beats, wrapped to ACC_W bits.
  function automatic logic [OW-1:0] model_row(input int r, input int k, input bit sgn);
    logic [OW-1:0] v;
    logic [63:0]   wrapped;
    longint        sum;
    v = '0;
    for (int j = 0; j < COLS; j++) begin
      sum = 0;
      for (int kk = 0; kk < k; kk++) sum += ext_val(op_a[r][kk], sgn) * ext_val(op_b[kk][j], sgn);
      wrapped = 64'(sum);
      v[j*ACC_W +: ACC_W] = wrapped[ACC_W-1:0];
    end
    return v;
  endfunction

  task automatic fill_ops(input int mode);
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < K_MAX; k++) op_a[i][k] = (mode == 0) ? 0 : (mode == 1) ? 255 : int'($urandom_range(0, 255));
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < COLS; j++) op_b[k][j] = (mode == 0) ? 0 : (mode == 1) ? 255 : int'($urandom_range(0, 255));
  endtask

  // One complete job. bubble_mode 0 = none, 1 = random, 2 = repeating 1-0-0-1 valid pattern.
  task automatic applyStimulus(input string tag, input int k_req, input bit sgn,
                               input int bubble_mode, input int stall_cycles, input bit rand_ready);
    int k_eff, beat, accepted, cycles, guard, row, stall_left, first_valid;
    bit v, took, hs;
    k_eff = (k_req > K_MAX) ? K_MAX : k_req;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k_req); signed_mode = sgn; in_valid = 1'b0; out_ready = 1'b0;
    cycles = 0; first_valid = -1;
    @(negedge clk);
    cycles = 1; start = 1'b0;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    if (k_eff == 0) checkOutput({tag, "_noload"}, 64'(in_ready), 64'd0);

    beat = 0; accepted = 0; guard = 0;
    while (beat < k_eff && guard < 400) begin
      case (bubble_mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = ((guard % 4) == 0) || ((guard % 4) == 3);
      endcase
      in_valid = v;
      if (v) begin
        for (int i = 0; i < ROWS; i++) a_in[i*DATA_W +: DATA_W] = DATA_W'(op_a[i][beat]);
        for (int j = 0; j < COLS; j++) b_in[j*DATA_W +: DATA_W] = DATA_W'(op_b[beat][j]);
      end else begin
        a_in = AW'($urandom);
        b_in = BW'($urandom);
      end
      start       = ($urandom_range(0, 3) == 0);
      k_len       = KW'($urandom_range(0, 15));
      signed_mode = 1'($urandom_range(0, 1));
      took = v && in_ready;
      @(negedge clk);
      cycles++; guard++;
      if (took) begin
        beat++;
        accepted++;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    checkOutput({tag, "_beats"}, 64'(accepted), 64'(k_eff));
    if (k_eff > 0) checkOutput({tag, "_ready_after_last"}, 64'(in_ready), 64'd0);

    row = 0; guard = 0; stall_left = stall_cycles;
    while (row < ROWS && guard < 200) begin
      hs = 1'b0;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cycles;
        checkOutput({tag, "_row_idx"}, 64'(out_row), 64'(row));
        checkOutput({tag, "_row_data"}, 64'(out_data), 64'(model_row(row, k_eff, sgn)));
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        hs = out_ready;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      start = !(hs && row == ROWS - 1) && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cycles++; guard++;
      if (hs) row++;
    end
    start = 1'b0; out_ready = 1'b0;
    checkOutput({tag, "_rows"}, 64'(row), 64'(ROWS));
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    checkOutput({tag, "_valid_off"}, 64'(out_valid), 64'd0);
    if (bubble_mode == 0)
      checkOutput({tag, "_latency"}, 64'(first_valid), (k_eff == 0) ? 64'd1 : 64'(k_eff + ROWS + COLS));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic resetMidJob();
    fill_ops(2);
    @(negedge clk);
    start = 1'b1; k_len = KW'(5); signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_in = AW'($urandom); b_in = BW'($urandom);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_data", 64'(out_data), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; in_valid = 1'b0;
    a_in = '0; b_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_row", 64'(out_row), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    // A = [[1,2],[3,4]], B = identity in the top-left corner
    fill_ops(0);
    op_a[0][0] = 1; op_a[0][1] = 2; op_a[1][0] = 3; op_a[1][1] = 4;
    op_b[0][0] = 1; op_b[1][1] = 1;
    applyStimulus("t1_ident", 2, 1'b0, 0, 0, 1'b0);

    // A column [-1,-2], B row [3,-4], signed and then unsigned
    fill_ops(0);
    op_a[0][0] = 255; op_a[1][0] = 254; op_b[0][0] = 3; op_b[0][1] = 252;
    applyStimulus("t2_signed", 1, 1'b1, 0, 0, 1'b0);
    applyStimulus("t2_unsigned", 1, 1'b0, 0, 0, 1'b0);

    fill_ops(2);
    applyStimulus("t3_bubbles", 4, 1'b0, 2, 0, 1'b0);

    fill_ops(2);
    applyStimulus("t4_stall", 3, 1'b1, 0, 5, 1'b0);

    fill_ops(2);
    applyStimulus("t5_k0", 0, 1'b0, 0, 0, 1'b0);

    // All operands 255 unsigned, K=2: 2*255*255 wraps to 0xFC02 in 16 bits
    fill_ops(1);
    applyStimulus("t6_wrap", 2, 1'b0, 0, 0, 1'b0);
    checkOutput("t6_model_const", 64'(model_row(0, 2, 1'b0)), 64'hFC02_FC02_FC02_FC02);

    fill_ops(2);
    applyStimulus("k_clamp", 13, 1'b1, 0, 0, 1'b0);

    resetMidJob();
    fill_ops(2);
    applyStimulus("after_rst", 5, 1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      fill_ops(2);
      applyStimulus("rand_job", int'($urandom_range(0, K_MAX)), 1'($urandom_range(0, 1)),
                    1, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
